echo_delay_ctrl: RTL and testbench

- Sequences a single-port synchronous RAM used as a circular delay line for the echo datapath.
- Turns the ADC data_valid level into one sample strobe per rising edge and captures the current 10-bit processed sample.
- Per strobe, reads the sample written delay_len samples earlier, then writes the new sample. The echo sample is presented to the mixer with a valid flag.
- Replaces the full-flag/FIFO priming arrangement with an explicitly programmable delay.

---
 rtl/echo_pkg.sv | 15 +
 rtl/valid_edge_det.sv | 19 +
 rtl/echo_delay_ctrl.sv | 138 +++++++++++++
 tb/tb_echo_delay_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared constants and types for the echo delay-line controller.
`timescale 1ns/1ps
package echo_pkg;
  localparam int DATA_W = 10;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RDW,
    WR
  } state_e;

  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/valid_edge_det.sv
// Turns a sample-ready level into a single-cycle strobe on its rising edge.
`timescale 1ns/1ps
module valid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic strobe
);
  logic lvl_q, lvl_d;

  always_comb lvl_d = level;

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl_d;
  end

  assign strobe = level & ~lvl_q;
endmodule

// File: rtl/echo_delay_ctrl.sv
// Circular delay-line sequencer for the echo path (RD, RDW, WR per sample).
// Define ECHO_ATTEN_EN to shift the echo sample right by ATTEN_SHIFT.
`timescale 1ns/1ps
module echo_delay_ctrl #(
  parameter int ADDR_W      = echo_pkg::ADDR_W,
  parameter int DATA_W      = echo_pkg::DATA_W,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] delay_len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] echo_out,
  output logic              echo_valid,
  output logic              primed,
  output logic              overrun
);
  import echo_pkg::*;

`ifdef ECHO_ATTEN_EN
  localparam int ATTEN_ON = 1;
`else
  localparam int ATTEN_ON = 0;
`endif
  localparam int SHIFT = ATTEN_SHIFT * ATTEN_ON;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] dl_q, dl_d;
  logic [DATA_W-1:0] samp_q, samp_d;
  logic [DATA_W-1:0] echo_out_q, echo_out_d;
  logic echo_valid_q, echo_valid_d;
  logic primed_q, primed_d;
  logic overrun_q, overrun_d;

  logic strobe;
  logic [ADDR_W-1:0] eff_len, rd_ptr, fill_inc;
  logic [DATA_W-1:0] echo_shf;

  valid_edge_det u_edge (
    .clk    (sysclk),
    .rst    (reset),
    .level  (data_valid),
    .strobe (strobe)
  );

  assign eff_len  = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  assign rd_ptr   = wr_ptr_q - eff_len;
  assign fill_inc = (fill_q >= eff_len) ? eff_len
                                        : fill_q + ADDR_W'(1);
  assign echo_shf = DATA_W'($signed(ram_rdata) >>> SHIFT);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    dl_d         = delay_len;
    samp_d       = samp_q;
    echo_out_d   = echo_out_q;
    echo_valid_d = 1'b0;
    primed_d     = primed_q;
    overrun_d    = overrun_q;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wdata    = '0;

    if (strobe) begin
      if (state_q == IDLE) samp_d = sample_in;
      else                 overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: if (strobe) state_d = RD;
      RD: begin
        ram_addr = rd_ptr;
        state_d  = RDW;
      end
      RDW: begin
        ram_addr     = rd_ptr;
        echo_out_d   = primed_q ? echo_shf : '0;
        echo_valid_d = 1'b1;
        state_d      = WR;
      end
      WR: begin
        // Gate by reset so an abort in WR never commits a write.
        ram_addr  = wr_ptr_q;
        ram_we    = ~reset;
        ram_wdata = samp_q;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        fill_d    = fill_inc;
        primed_d  = (fill_inc >= eff_len);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new delay invalidates the history; this wins over the WR update.
    if (delay_len != dl_q) begin
      fill_d   = '0;
      primed_d = 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      dl_q         <= '0;
      samp_q       <= '0;
      echo_out_q   <= '0;
      echo_valid_q <= 1'b0;
      primed_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      dl_q         <= dl_d;
      samp_q       <= samp_d;
      echo_out_q   <= echo_out_d;
      echo_valid_q <= echo_valid_d;
      primed_q     <= primed_d;
      overrun_q    <= overrun_d;
    end
  end

  assign echo_out   = echo_out_q;
  assign echo_valid = echo_valid_q;
  assign primed     = primed_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl with a small (8-entry) behavioural RAM.
`timescale 1ns/1ps
module tb_echo_delay_ctrl;
  localparam int AW = 3;
  localparam int DW = 10;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          data_valid;
  logic [DW-1:0] sample_in;
  logic [AW-1:0] delay_len;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] echo_out;
  logic          echo_valid;
  logic          primed;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int nwr = 0;
  int wp = 0;

  logic [DW-1:0] mem [8];

  logic [AW-1:0] c_rd_addr, c_wr_addr;
  logic          c_rd_we, c_wr_we, c_ev, c_ev_after, c_primed;
  logic [DW-1:0] c_echo, c_wdata;

  echo_delay_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ATTEN_SHIFT(1)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .data_valid (data_valid),
    .sample_in  (sample_in),
    .delay_len  (delay_len),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .echo_out   (echo_out),
    .echo_valid (echo_valid),
    .primed     (primed),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      nwr <= nwr + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic run_sample(input logic [DW-1:0] s);
    @(negedge sysclk);
    data_valid = 1'b1;
    sample_in  = s;
    @(negedge sysclk);
    data_valid = 1'b0;
    c_rd_addr  = ram_addr;
    c_rd_we    = ram_we;
    @(negedge sysclk);
    @(negedge sysclk);
    c_wr_addr  = ram_addr;
    c_wr_we    = ram_we;
    c_wdata    = ram_wdata;
    c_ev       = echo_valid;
    c_echo     = echo_out;
    @(negedge sysclk);
    c_ev_after = echo_valid;
    c_primed   = primed;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_valid = 1'b0;
    sample_in  = '0;
    delay_len  = 3'd4;
    repeat (2) @(negedge sysclk);
    checks++;
    if ({echo_out, echo_valid, primed, overrun} !== 13'd0) begin
      errors++;
      $display("FAIL reset_out echo=%0h ev=%b pr=%b ov=%b exp all 0",
               echo_out, echo_valid, primed, overrun);
    end
    checks++;
    if ({ram_addr, ram_we, ram_wdata} !== 14'd0) begin
      errors++;
      $display("FAIL reset_ram addr=%0d we=%b wd=%0h exp 0",
               ram_addr, ram_we, ram_wdata);
    end
    reset = 1'b0;
    wp = 0;
  endtask

  task automatic test_steady();
    logic [AW-1:0] ea;
    logic [DW-1:0] ee;
    for (int n = 1; n <= 10; n++) begin
      run_sample(DW'(n));
      ea = AW'(wp - 4);
      checks++;
      if (c_rd_we !== 1'b0 || c_rd_addr !== ea) begin
        errors++;
        $display("FAIL steady_rd n=%0d addr=%0d we=%b exp addr=%0d we=0",
                 n, c_rd_addr, c_rd_we, ea);
      end
      checks++;
      if (c_wr_we !== 1'b1 || c_wr_addr !== AW'(wp) ||
          c_wdata !== DW'(n)) begin
        errors++;
        $display("FAIL steady_wr n=%0d addr=%0d we=%b wd=%0d exp %0d 1 %0d",
                 n, c_wr_addr, c_wr_we, c_wdata, AW'(wp), n);
      end
      checks++;
      if (c_ev !== 1'b1 || c_ev_after !== 1'b0) begin
        errors++;
        $display("FAIL steady_valid n=%0d ev=%b next=%b exp 1 0",
                 n, c_ev, c_ev_after);
      end
      ee = (n >= 5) ? DW'(n - 4) : '0;
      checks++;
      if (c_echo !== ee) begin
        errors++;
        $display("FAIL steady_echo n=%0d got=%0d exp=%0d", n, c_echo, ee);
      end
      checks++;
      if (c_primed !== (n >= 4)) begin
        errors++;
        $display("FAIL steady_primed n=%0d got=%b exp=%b",
                 n, c_primed, (n >= 4));
      end
      wp = (wp + 1) % 8;
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ee;
    @(negedge sysclk);
    delay_len = 3'd3;
    @(negedge sysclk);
    checks++;
    if (primed !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear primed=%b exp 0", primed);
    end
    for (int k = 0; k < 20; k++) begin
      run_sample(DW'(101 + k));
      ee = (k >= 3) ? DW'(101 + k - 3) : '0;
      checks++;
      if (c_echo !== ee || c_wr_addr !== AW'(wp)) begin
        errors++;
        $display("FAIL wrap k=%0d echo=%0d addr=%0d exp %0d %0d",
                 k, c_echo, c_wr_addr, ee, AW'(wp));
      end
      wp = (wp + 1) % 8;
    end
  endtask

  task automatic test_zero_delay();
    logic [DW-1:0] ins [3];
    logic [DW-1:0] exp [3];
    ins = '{10'd5, 10'd6, 10'd7};
    exp = '{10'd0, 10'd5, 10'd6};
    @(negedge sysclk);
    delay_len = 3'd0;
    for (int k = 0; k < 3; k++) begin
      run_sample(ins[k]);
      checks++;
      if (c_echo !== exp[k] || c_primed !== 1'b1) begin
        errors++;
        $display("FAIL zero_delay k=%0d echo=%0d primed=%b exp %0d 1",
                 k, c_echo, c_primed, exp[k]);
      end
      wp = (wp + 1) % 8;
    end
  endtask

  task automatic test_delay_change();
    logic [DW-1:0] exp [10];
    exp = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd21, 10'd22,
            10'd0, 10'd0, 10'd27, 10'd28};
    @(negedge sysclk);
    delay_len = 3'd4;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) begin
        @(negedge sysclk);
        delay_len = 3'd2;
        @(negedge sysclk);
        checks++;
        if (primed !== 1'b0) begin
          errors++;
          $display("FAIL dchg_primed_drop got=%b exp 0", primed);
        end
      end
      run_sample(DW'(21 + k));
      checks++;
      if (c_echo !== exp[k]) begin
        errors++;
        $display("FAIL dchg_echo k=%0d got=%0d exp=%0d", k, c_echo, exp[k]);
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (c_primed !== (k == 7)) begin
          errors++;
          $display("FAIL dchg_primed k=%0d got=%b exp=%b",
                   k, c_primed, (k == 7));
        end
      end
      wp = (wp + 1) % 8;
    end
  endtask

  task automatic test_overrun();
    int w0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pre got=%b exp 0", overrun);
    end
    w0 = nwr;
    @(negedge sysclk);
    data_valid = 1'b1;
    sample_in  = 10'd77;
    @(negedge sysclk);
    data_valid = 1'b0;
    @(negedge sysclk);
    data_valid = 1'b1;
    sample_in  = 10'd88;
    @(negedge sysclk);
    data_valid = 1'b0;
    checks++;
    if (ram_we !== 1'b1 || ram_wdata !== 10'd77 || ram_addr !== AW'(wp)) begin
      errors++;
      $display("FAIL ovr_wr we=%b wd=%0d addr=%0d exp 1 77 %0d",
               ram_we, ram_wdata, ram_addr, AW'(wp));
    end
    @(negedge sysclk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag got=%b exp 1", overrun);
    end
    repeat (2) @(negedge sysclk);
    checks++;
    if (nwr - w0 != 1 || mem[wp] !== 10'd77) begin
      errors++;
      $display("FAIL ovr_writes n=%0d mem=%0d exp 1 77", nwr - w0, mem[wp]);
    end
    wp = (wp + 1) % 8;
    run_sample(10'd55);
    checks++;
    if (c_wr_addr !== AW'(wp) || c_wdata !== 10'd55 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after addr=%0d wd=%0d ov=%b exp %0d 55 1",
               c_wr_addr, c_wdata, overrun, AW'(wp));
    end
    wp = (wp + 1) % 8;
  endtask

  task automatic test_atten();
    logic [DW-1:0] ins [3];
    logic [DW-1:0] exp [3];
    ins = '{10'h3F8, 10'd7, 10'd0};
`ifdef ECHO_ATTEN_EN
    exp = '{10'd0, 10'h3FC, 10'd3};
`else
    exp = '{10'd0, 10'h3F8, 10'd7};
`endif
    @(negedge sysclk);
    delay_len = 3'd1;
    for (int k = 0; k < 3; k++) begin
      run_sample(ins[k]);
      checks++;
      if (c_echo !== exp[k]) begin
        errors++;
        $display("FAIL atten k=%0d got=%0h exp=%0h", k, c_echo, exp[k]);
      end
      wp = (wp + 1) % 8;
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    @(negedge sysclk);
    data_valid = 1'b1;
    sample_in  = 10'd99;
    @(negedge sysclk);
    data_valid = 1'b0;
    repeat (2) @(negedge sysclk);
    w0 = nwr;
    reset = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rmid_we_in_wr got=%b exp 0", ram_we);
    end
    @(negedge sysclk);
    checks++;
    if ({ram_we, echo_valid, primed, overrun} !== 4'd0) begin
      errors++;
      $display("FAIL rmid_state we=%b ev=%b pr=%b ov=%b exp 0",
               ram_we, echo_valid, primed, overrun);
    end
    reset = 1'b0;
    @(negedge sysclk);
    checks++;
    if (nwr != w0) begin
      errors++;
      $display("FAIL rmid_nowrite writes=%0d exp 0", nwr - w0);
    end
    wp = 0;
    run_sample(10'd40);
    checks++;
    if (c_wr_addr !== 3'd0 || c_echo !== 10'd0) begin
      errors++;
      $display("FAIL rmid_ptr addr=%0d echo=%0d exp 0 0", c_wr_addr, c_echo);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 10'h155;
    test_reset();
    test_steady();
    test_wrap();
    test_zero_delay();
    test_delay_change();
    test_overrun();
    test_atten();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
